dummy_accelerator_result_queue: RTL and testbench

In-order, variable-latency result stage that sits directly downstream of the dummy accelerator pipeline control unit and its datapath. It accepts one operation per cycle, each tagged with a latency `lat_i`, and holds it in a small queue. It returns each result to the core in issue order once that entry's latency has elapsed. Back-pressure comes from the core via `ready_i`. Latency-0 operations bypass the queue combinationally when the queue is empty.

---
 rtl/dummy_accelerator_result_queue.sv | 87 ++++++++
 tb/tb_dummy_accelerator_result_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dummy_accelerator_result_queue.sv
// In-order variable-latency result queue with latency-0 bypass.
// Each entry counts down its latency and is returned strictly in issue order.
module dummy_accelerator_result_queue #(
    parameter int DATA_W = 64,
    parameter int LAT_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LAT_W-1:0]  lat_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [LAT_W-1:0]  r_cnt  [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [OCC_W-1:0]  r_occ;

    logic             w_empty;
    logic             w_head_rdy;
    logic             w_bypass;
    logic             w_bypass_fire;
    logic             w_push;
    logic             w_pop;
    logic [LAT_W-1:0] w_new_cnt;

    assign w_empty       = (r_occ == '0);
    assign w_head_rdy    = !w_empty && (r_cnt[r_head] == '0);
    assign w_bypass      = w_empty && valid_i && (lat_i == '0);
    assign w_bypass_fire = w_bypass && ready_i;
    assign ready_o       = (r_occ < OCC_W'(DEPTH));
    assign w_push        = valid_i && ready_o && !w_bypass_fire;
    assign w_pop         = w_head_rdy && ready_i;
    assign w_new_cnt     = (lat_i == '0) ? '0 : lat_i - LAT_W'(1);
    assign valid_o       = w_head_rdy || w_bypass;

    always_comb begin
        data_o = '0;
        if (!w_empty) begin
            data_o = r_data[r_head];
        end else if (w_bypass) begin
            data_o = data_i;
        end
    end

    // Free-running countdown; a fresh write overrides its slot's decrement.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (r_cnt[i] != '0) begin
                r_cnt[i] <= r_cnt[i] - LAT_W'(1);
            end
        end
        if (w_push) begin
            r_data[r_tail] <= data_i;
            r_cnt[r_tail]  <= w_new_cnt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - OCC_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_dummy_accelerator_result_queue.sv
// Bench for dummy_accelerator_result_queue: vector table plus
// scoreboard-checked multi-cycle sequences.
module tb_dummy_accelerator_result_queue;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [63:0] data_i;
    logic [3:0]  lat_i;
    logic        valid_o;
    logic        ready_i;
    logic [63:0] data_o;

    dummy_accelerator_result_queue #(
        .DATA_W(64),
        .LAT_W (4),
        .DEPTH (4)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .flush_i(flush_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i (data_i),
        .lat_i  (lat_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .data_o (data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        v;
        logic [3:0]  l;
        logic [63:0] d;
        logic        r;
        logic        evo;
        logic [63:0] edo;
        logic        erdy;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        int          c;
    } sb_t;

    int   tests  = 0;
    int   failed = 0;
    int   cyc    = 0;
    sb_t  sb[$];
    vec_t tv[13];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk_i);
        cyc++;
        #1;
    endtask

    // One cycle: drive, sample at negedge, retire outputs into scoreboard.
    task automatic tick(input logic v, input logic [3:0] l,
                        input logic [63:0] d, input logic r,
                        input logic f, input int erdy, input int evo);
        sb_t e;
        valid_i = v;
        lat_i   = l;
        data_i  = d;
        ready_i = r;
        flush_i = f;
        @(negedge clk_i);
        if (erdy >= 0) chk("ready_o", {63'b0, ready_o}, 64'(erdy));
        if (evo >= 0) chk("valid_o", {63'b0, valid_o}, 64'(evo));
        if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL sb_spurious @cyc %0d: got data %0h expected no output",
                         cyc, data_o);
            end else begin
                e = sb.pop_front();
                chk("sb_data", data_o, e.d);
                chk("sb_cycle", 64'(cyc), 64'(e.c));
            end
        end
        adv();
    endtask

    task automatic sb_push(input logic [63:0] d, input int c);
        sb_t e;
        e.d = d;
        e.c = c;
        sb.push_back(e);
    endtask

    initial begin
        int t;
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        valid_i = 1'b1;
        lat_i   = 4'd1;
        data_i  = 64'h5;
        ready_i = 1'b1;

        // Reset held two cycles with valid_i high
        adv();
        @(negedge clk_i);
        chk("rst_valid_o", {63'b0, valid_o}, 64'd0);
        chk("rst_ready_o", {63'b0, ready_o}, 64'd1);
        chk("rst_data_o", data_o, 64'd0);
        adv();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0, 4'd0, 64'd0, 1'b1, 1'b0, 1, 0);

        // Cycle-by-cycle vectors starting from an empty queue
        tv[0]  = '{1'b0, 4'd0, 64'h0,  1'b1, 1'b0, 64'h0,  1'b1};
        tv[1]  = '{1'b1, 4'd0, 64'hA5, 1'b1, 1'b1, 64'hA5, 1'b1};
        tv[2]  = '{1'b0, 4'd0, 64'h0,  1'b1, 1'b0, 64'h0,  1'b1};
        tv[3]  = '{1'b1, 4'd0, 64'h3C, 1'b0, 1'b1, 64'h3C, 1'b1};
        tv[4]  = '{1'b0, 4'd0, 64'h0,  1'b0, 1'b1, 64'h3C, 1'b1};
        tv[5]  = '{1'b1, 4'd0, 64'h77, 1'b1, 1'b1, 64'h3C, 1'b1};
        tv[6]  = '{1'b0, 4'd0, 64'h0,  1'b1, 1'b1, 64'h77, 1'b1};
        tv[7]  = '{1'b0, 4'd0, 64'h0,  1'b1, 1'b0, 64'h0,  1'b1};
        tv[8]  = '{1'b1, 4'd3, 64'h11, 1'b1, 1'b0, 64'h0,  1'b1};
        tv[9]  = '{1'b0, 4'd0, 64'h0,  1'b1, 1'b0, 64'h11, 1'b1};
        tv[10] = '{1'b0, 4'd0, 64'h0,  1'b1, 1'b0, 64'h11, 1'b1};
        tv[11] = '{1'b0, 4'd0, 64'h0,  1'b1, 1'b1, 64'h11, 1'b1};
        tv[12] = '{1'b0, 4'd0, 64'h0,  1'b1, 1'b0, 64'h0,  1'b1};
        for (int i = 0; i < 13; i++) begin
            valid_i = tv[i].v;
            lat_i   = tv[i].l;
            data_i  = tv[i].d;
            ready_i = tv[i].r;
            @(negedge clk_i);
            chk($sformatf("vec%0d_valid_o", i), {63'b0, valid_o}, {63'b0, tv[i].evo});
            chk($sformatf("vec%0d_data_o", i), data_o, tv[i].edo);
            chk($sformatf("vec%0d_ready_o", i), {63'b0, ready_o}, {63'b0, tv[i].erdy});
            adv();
        end

        // Latency and order: lat 5 then lat 1
        t = cyc;
        sb_push(64'd1, t + 5);
        sb_push(64'd2, t + 6);
        tick(1'b1, 4'd5, 64'd1, 1'b1, 1'b0, 1, 0);
        tick(1'b1, 4'd1, 64'd2, 1'b1, 1'b0, 1, 0);
        for (int i = 2; i < 9; i++) tick(1'b0, 4'd0, 64'd0, 1'b1, 1'b0, 1, -1);
        chk("lat_drain", 64'(sb.size()), 64'd0);

        // Full queue and back-pressure
        t = cyc;
        for (int i = 0; i < 4; i++) sb_push(64'h10 + 64'(i), t + 5 + i);
        for (int i = 0; i < 4; i++)
            tick(1'b1, 4'd1, 64'h10 + 64'(i), 1'b0, 1'b0, 1, -1);
        tick(1'b1, 4'd1, 64'h99, 1'b0, 1'b0, 0, 1);
        tick(1'b0, 4'd0, 64'd0, 1'b1, 1'b0, 0, 1);
        tick(1'b0, 4'd0, 64'd0, 1'b1, 1'b0, 1, 1);
        tick(1'b0, 4'd0, 64'd0, 1'b1, 1'b0, 1, 1);
        tick(1'b0, 4'd0, 64'd0, 1'b1, 1'b0, 1, 1);
        tick(1'b0, 4'd0, 64'd0, 1'b1, 1'b0, 1, 0);
        chk("full_drain", 64'(sb.size()), 64'd0);

        // Pointer wrap: ten back-to-back lat-2 operations
        t = cyc;
        for (int i = 0; i < 10; i++) begin
            sb_push(64'(i), t + 2 + i);
            tick(1'b1, 4'd2, 64'(i), 1'b1, 1'b0, 1, -1);
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 4'd0, 64'd0, 1'b1, 1'b0, 1, -1);
        chk("wrap_drain", 64'(sb.size()), 64'd0);

        // Flush with a concurrent push
        for (int i = 0; i < 3; i++)
            tick(1'b1, 4'd7, 64'h70 + 64'(i), 1'b0, 1'b0, 1, 0);
        tick(1'b1, 4'd7, 64'h7F, 1'b1, 1'b1, 1, 0);
        for (int i = 0; i < 10; i++) tick(1'b0, 4'd0, 64'd0, 1'b1, 1'b0, 1, 0);

        // Reset in the middle of a countdown
        tick(1'b1, 4'd9, 64'hEE, 1'b0, 1'b0, 1, 0);
        tick(1'b0, 4'd0, 64'd0, 1'b0, 1'b0, -1, 0);
        rst_ni = 1'b0;
        tick(1'b0, 4'd0, 64'd0, 1'b1, 1'b0, -1, 0);
        rst_ni = 1'b1;
        for (int i = 0; i < 12; i++) tick(1'b0, 4'd0, 64'd0, 1'b1, 1'b0, 1, 0);
        chk("final_drain", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
